// File: rtl/usb_in_arbiter.sv
// Packet-granular round-robin arbiter feeding the single USB bulk IN AXI-Stream channel.
// A granted source owns the channel until its tlast beat; an optional header beat tags each packet.
module usb_in_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NUM_SRC = 4,
   parameter int HEADER  = 1
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [NUM_SRC-1:0]         s_axis_tvalid_i,
   output logic [NUM_SRC-1:0]         s_axis_tready_o,
   input  logic [NUM_SRC-1:0]         s_axis_tlast_i,
   input  logic [NUM_SRC*WIDTH-1:0]   s_axis_tdata_i,
   output logic                       m_axis_tvalid_o,
   input  logic                       m_axis_tready_i,
   output logic                       m_axis_tlast_o,
   output logic [WIDTH-1:0]           m_axis_tdata_o,
   output logic [NUM_SRC-1:0]         grant_o,
   output logic                       busy_o
);

   localparam int SBITS = $clog2(NUM_SRC);
   localparam logic [SBITS-1:0] LAST_SRC = SBITS'(NUM_SRC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAD = 2'd1,
      XFER = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [SBITS-1:0] grant;
   logic [SBITS-1:0] grant_nx;
   logic [SBITS-1:0] ptr;
   logic [SBITS-1:0] ptr_nx;

   logic [SBITS-1:0] pick;
   logic [SBITS-1:0] pick_hi;
   logic [SBITS-1:0] pick_lo;
   logic             found_hi;
   logic             req_any;
   logic             last_hs;
   logic [2:0]       grant_tag;
   logic [7:0]       tag;
   logic [WIDTH-1:0] src_data [NUM_SRC];

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_data[i] = s_axis_tdata_i[i*WIDTH +: WIDTH];
      end
   end

   // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      pick_hi  = '0;
      pick_lo  = '0;
      found_hi = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (s_axis_tvalid_i[i]) begin
            pick_lo = SBITS'(i);
            if (SBITS'(i) >= ptr) begin
               pick_hi  = SBITS'(i);
               found_hi = 1'b1;
            end
         end
      end
      pick    = found_hi ? pick_hi : pick_lo;
      req_any = |s_axis_tvalid_i;
   end

   assign last_hs   = s_axis_tvalid_i[grant] & m_axis_tready_i & s_axis_tlast_i[grant];
   assign grant_tag = 3'(grant);
   assign tag       = {4'hA, 1'b0, grant_tag};

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         ptr   <= ptr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      ptr_nx   = ptr;
      case (state)
         IDLE: begin
            if (req_any) begin
               grant_nx = pick;
               state_nx = (HEADER != 0) ? HEAD : XFER;
            end
         end
         HEAD: begin
            if (m_axis_tready_i) begin
               state_nx = XFER;
            end
         end
         XFER: begin
            if (last_hs) begin
               ptr_nx   = (grant == LAST_SRC) ? '0 : grant + SBITS'(1);
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Outside XFER the data bus carries only the tag or zero, never source data.
   always_comb begin
      m_axis_tvalid_o = 1'b0;
      m_axis_tlast_o  = 1'b0;
      m_axis_tdata_o  = '0;
      s_axis_tready_o = '0;
      busy_o          = 1'b0;
      case (state)
         HEAD: begin
            m_axis_tvalid_o     = 1'b1;
            m_axis_tdata_o[7:0] = tag;
            busy_o              = 1'b1;
         end
         XFER: begin
            m_axis_tvalid_o        = s_axis_tvalid_i[grant];
            m_axis_tlast_o         = s_axis_tlast_i[grant];
            m_axis_tdata_o         = src_data[grant];
            s_axis_tready_o[grant] = m_axis_tready_i;
            busy_o                 = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      grant_o = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         grant_o[i] = (state != IDLE) && (grant == SBITS'(i));
      end
   end

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Directed bench for usb_in_arbiter: cycle-vector table plus hand-written traffic,
// fairness, reset and header-less sequences.
module tb_usb_in_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           areset;
   logic [N-1:0]   s_valid, s_last, s_ready;
   logic [N*W-1:0] s_data;
   logic           m_valid, m_ready, m_last;
   logic [W-1:0]   m_data;
   logic [N-1:0]   grant;
   logic           busy;

   logic [N-1:0]   nh_s_valid, nh_s_last, nh_s_ready;
   logic [N*W-1:0] nh_s_data;
   logic           nh_m_valid, nh_m_ready, nh_m_last;
   logic [W-1:0]   nh_m_data;
   logic [N-1:0]   nh_grant;
   logic           nh_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   usb_in_arbiter #(.WIDTH(W), .NUM_SRC(N), .HEADER(1)) dut (
      .aclk(clk), .areset(areset),
      .s_axis_tvalid_i(s_valid), .s_axis_tready_o(s_ready),
      .s_axis_tlast_i(s_last), .s_axis_tdata_i(s_data),
      .m_axis_tvalid_o(m_valid), .m_axis_tready_i(m_ready),
      .m_axis_tlast_o(m_last), .m_axis_tdata_o(m_data),
      .grant_o(grant), .busy_o(busy)
   );

   usb_in_arbiter #(.WIDTH(W), .NUM_SRC(N), .HEADER(0)) dut_nh (
      .aclk(clk), .areset(areset),
      .s_axis_tvalid_i(nh_s_valid), .s_axis_tready_o(nh_s_ready),
      .s_axis_tlast_i(nh_s_last), .s_axis_tdata_i(nh_s_data),
      .m_axis_tvalid_o(nh_m_valid), .m_axis_tready_i(nh_m_ready),
      .m_axis_tlast_o(nh_m_last), .m_axis_tdata_o(nh_m_data),
      .grant_o(nh_grant), .busy_o(nh_busy)
   );

   // {tvalid, tlast, tdata, s_ready, grant, busy}
   function automatic logic [18:0] o(logic mv, logic ml, logic [7:0] md,
                                     logic [3:0] sr, logic [3:0] gr, logic b);
      return {mv, ml, md, sr, gr, b};
   endfunction

   wire [18:0] obs    = {m_valid, m_last, m_data, s_ready, grant, busy};
   wire [18:0] nh_obs = {nh_m_valid, nh_m_last, nh_m_data, nh_s_ready, nh_grant, nh_busy};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
      nh_s_valid = '0; nh_s_last = '0; nh_s_data = '0; nh_m_ready = 1'b1;
   endtask

   task automatic do_reset();
      areset = 1'b1;
      clear_inputs();
      tick();
      tick();
      areset = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      logic        r;
      logic [18:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [31:0] d, logic r,
                               logic [18:0] exp);
      vec_t x;
      x.v = v; x.l = l; x.d = d; x.r = r; x.exp = exp;
      return x;
   endfunction

   // Traffic capture: every accepted output beat with its cycle index.
   logic [7:0] cap_d[$];
   bit         cap_l[$];
   int         cap_c[$];
   int         bcnt[N];

   // Each source in mask streams 2-beat packets: data = i*16 + beat + 1, tlast on beat 1.
   task automatic run_traffic(input logic [3:0] mask, input int ncyc);
      logic [3:0] hs;
      cap_d.delete(); cap_l.delete(); cap_c.delete();
      for (int i = 0; i < N; i++) bcnt[i] = 0;
      m_ready = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         s_valid = mask;
         for (int i = 0; i < N; i++) begin
            s_data[i*W +: W] = 8'(i * 16 + bcnt[i] + 1);
            s_last[i]        = (bcnt[i] == 1);
         end
         @(negedge clk);
         if (m_valid && m_ready) begin
            cap_d.push_back(m_data);
            cap_l.push_back(m_last);
            cap_c.push_back(c);
         end
         hs = s_ready & s_valid;
         tick();
         for (int i = 0; i < N; i++) if (hs[i]) bcnt[i] = 1 - bcnt[i];
      end
      clear_inputs();
   endtask

   int exp_src;
   int fair_src[4] = '{0, 3, 0, 3};

   initial begin
      // Reset state with busy inputs present
      areset = 1'b1;
      clear_inputs();
      s_valid = 4'b1111; s_data = 32'hDEADBEEF; s_last = 4'b1111;
      @(negedge clk);
      chk("reset_outputs", obs, o(0, 0, 8'h00, 4'h0, 4'h0, 0));
      tick();
      areset = 1'b0;
      clear_inputs();

      // Single source with header, then backpressure on source 2 (ptr=2 afterwards)
      tbl.push_back(mk(4'b0010, 4'b0000, 32'h0000_1100, 1, o(0, 0, 8'h00, 4'h0, 4'h0, 0)));
      tbl.push_back(mk(4'b0010, 4'b0000, 32'h0000_1100, 1, o(1, 0, 8'hA1, 4'h0, 4'b0010, 1)));
      tbl.push_back(mk(4'b0010, 4'b0000, 32'h0000_1100, 1, o(1, 0, 8'h11, 4'b0010, 4'b0010, 1)));
      tbl.push_back(mk(4'b0010, 4'b0000, 32'h0000_2200, 1, o(1, 0, 8'h22, 4'b0010, 4'b0010, 1)));
      tbl.push_back(mk(4'b0010, 4'b0010, 32'h0000_3300, 1, o(1, 1, 8'h33, 4'b0010, 4'b0010, 1)));
      tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, o(0, 0, 8'h00, 4'h0, 4'h0, 0)));
      tbl.push_back(mk(4'b0100, 4'b0000, 32'h0051_0000, 0, o(0, 0, 8'h00, 4'h0, 4'h0, 0)));
      tbl.push_back(mk(4'b0100, 4'b0000, 32'h0099_0000, 0, o(1, 0, 8'hA2, 4'h0, 4'b0100, 1)));
      tbl.push_back(mk(4'b0101, 4'b0000, 32'h0098_0000, 0, o(1, 0, 8'hA2, 4'h0, 4'b0100, 1)));
      tbl.push_back(mk(4'b0100, 4'b0100, 32'h0097_0000, 0, o(1, 0, 8'hA2, 4'h0, 4'b0100, 1)));
      tbl.push_back(mk(4'b0110, 4'b0000, 32'h0096_0000, 0, o(1, 0, 8'hA2, 4'h0, 4'b0100, 1)));
      tbl.push_back(mk(4'b0100, 4'b0000, 32'h0095_0000, 0, o(1, 0, 8'hA2, 4'h0, 4'b0100, 1)));
      tbl.push_back(mk(4'b0100, 4'b0000, 32'h0094_0000, 1, o(1, 0, 8'hA2, 4'h0, 4'b0100, 1)));
      tbl.push_back(mk(4'b0100, 4'b0000, 32'h0051_0000, 0, o(1, 0, 8'h51, 4'h0, 4'b0100, 1)));
      tbl.push_back(mk(4'b0100, 4'b0000, 32'h0051_0000, 1, o(1, 0, 8'h51, 4'b0100, 4'b0100, 1)));
      tbl.push_back(mk(4'b0001, 4'b0100, 32'h0052_0000, 0, o(0, 1, 8'h52, 4'h0, 4'b0100, 1)));
      tbl.push_back(mk(4'b0100, 4'b0100, 32'h0052_0000, 1, o(1, 1, 8'h52, 4'b0100, 4'b0100, 1)));
      tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, o(0, 0, 8'h00, 4'h0, 4'h0, 0)));

      foreach (tbl[k]) begin
         tick();
         s_valid = tbl[k].v; s_last = tbl[k].l; s_data = tbl[k].d; m_ready = tbl[k].r;
         @(negedge clk);
         chk($sformatf("vec%0d", k), obs, tbl[k].exp);
      end
      tick();
      clear_inputs();

      // All four sources continuously: order 0,1,2,3,0 with one idle cycle between packets
      do_reset();
      run_traffic(4'b1111, 20);
      chk("rr_beat_count", cap_d.size(), 15);
      if (cap_d.size() == 15) begin
         for (int k = 0; k < 5; k++) begin
            exp_src = k % 4;
            chk($sformatf("rr_hdr%0d", k), cap_d[3*k], 8'hA0 | 8'(exp_src));
            chk($sformatf("rr_hdr_cycle%0d", k), cap_c[3*k], 1 + 4*k);
            chk($sformatf("rr_b0_%0d", k), {cap_l[3*k+1], cap_d[3*k+1]}, {1'b0, 8'(exp_src*16 + 1)});
            chk($sformatf("rr_b1_%0d", k), {cap_l[3*k+2], cap_d[3*k+2]}, {1'b1, 8'(exp_src*16 + 2)});
         end
      end

      // Fairness between sources 0 and 3
      do_reset();
      run_traffic(4'b1001, 16);
      chk("fair_beat_count", cap_d.size(), 12);
      if (cap_d.size() == 12) begin
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("fair_hdr%0d", k), cap_d[3*k], 8'hA0 | 8'(fair_src[k]));
         end
      end

      // Reset on the second beat of a 4-beat packet from source 0
      do_reset();
      s_valid = 4'b0001; s_data = 32'h0000_00C0; m_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("rst_mid_beat0", obs, o(1, 0, 8'hC0, 4'b0001, 4'b0001, 1));
      tick();
      s_data = 32'h0000_00C1;
      areset = 1'b1;
      #1;
      chk("rst_mid_immediate", obs, o(0, 0, 8'h00, 4'h0, 4'h0, 0));
      tick();
      areset = 1'b0;
      s_valid = 4'b0010; s_last = 4'b0010; s_data = 32'h0000_D000;
      @(negedge clk);
      chk("rst_after_idle", obs, o(0, 0, 8'h00, 4'h0, 4'h0, 0));
      tick();
      @(negedge clk);
      chk("rst_after_head", obs, o(1, 0, 8'hA1, 4'h0, 4'b0010, 1));
      tick();
      @(negedge clk);
      chk("rst_after_beat", obs, o(1, 1, 8'hD0, 4'b0010, 4'b0010, 1));
      tick();
      clear_inputs();

      // No-header instance: single-beat packet from source 2, then ptr=3 prefers source 3 over 0
      do_reset();
      nh_s_valid = 4'b0100; nh_s_last = 4'b0100; nh_s_data = 32'h0077_0000;
      @(negedge clk);
      chk("nh_idle", nh_obs, o(0, 0, 8'h00, 4'h0, 4'h0, 0));
      tick();
      @(negedge clk);
      chk("nh_single_beat", nh_obs, o(1, 1, 8'h77, 4'b0100, 4'b0100, 1));
      tick();
      nh_s_valid = 4'b1001; nh_s_last = 4'b1001; nh_s_data = 32'h8800_0066;
      @(negedge clk);
      chk("nh_return_idle", nh_obs, o(0, 0, 8'h00, 4'h0, 4'h0, 0));
      tick();
      @(negedge clk);
      chk("nh_ptr_after_wrap", nh_obs, o(1, 1, 8'h88, 4'b1000, 4'b1000, 1));
      tick();
      clear_inputs();
      @(negedge clk);
      chk("nh_final_idle", nh_obs, o(0, 0, 8'h00, 4'h0, 4'h0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_in_arbiter.md
# usb_in_arbiter

Packet-granular round-robin arbiter that shares the single USB bulk IN AXI-Stream channel of `ulpi_bulk_axis` between up to eight AXI-Stream sources. It sits in the `aclk` domain between the application sources and the bulk core's IN slave port. Once a source is granted, it owns the channel until its `tlast` beat completes. An optional one-byte header tags each packet with its source index, so the host can demultiplex.

## Interface

Parameters:
- `WIDTH`, 8: data width in bits; must be ≥ 8.
- `NUM_SRC`, 4: number of sources, 2..8.
- `HEADER`, 1: 1 prepends a source-tag beat to each packet; 0 passes packets unmodified.
- `SBITS`, derived as `$clog2(NUM_SRC)`: width of the source index.

Ports:
- `aclk`  in  1  clock; all logic is on its rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `s_axis_tvalid_i`  in  NUM_SRC  per-source valid.
- `s_axis_tready_o`  out  NUM_SRC  per-source ready.
- `s_axis_tlast_i`  in  NUM_SRC  per-source end of packet.
- `s_axis_tdata_i`  in  NUM_SRC*WIDTH  per-source data; source i occupies `[i*WIDTH +: WIDTH]`.
- `m_axis_tvalid_o`  out  1  valid toward the bulk IN channel.
- `m_axis_tready_i`  in  1  ready from the bulk IN channel.
- `m_axis_tlast_o`  out  1  end of packet.
- `m_axis_tdata_o`  out  WIDTH  data.
- `grant_o`  out  NUM_SRC  one-hot current owner; all zero when idle.
- `busy_o`  out  1  high in HEAD or XFER.

## Operation

Registered state:
- FSM state: IDLE, HEAD, XFER.
- `grant` index, SBITS wide.
- Round-robin pointer `ptr`, SBITS wide.

IDLE:
- Outputs: `m_axis_tvalid_o`=0 and all `s_axis_tready_o`=0.
- If any `s_axis_tvalid_i` is high, select the first requester at or after `ptr`, searching upward with wrap at NUM_SRC.
- Register the selection as `grant`.
- Next state is HEAD if `HEADER`=1, otherwise XFER.

HEAD:
- `m_axis_tvalid_o`=1, `m_axis_tlast_o`=0.
- `m_axis_tdata_o` = zero-extended `{4'hA, 1'b0, grant[2:0]}`; for example, source 2 gives 8'hA2.
- All `s_axis_tready_o`=0.
- On `m_axis_tready_i`=1, go to XFER.

XFER is combinational pass-through of source `grant`:
- `m_axis_tvalid_o` = `s_axis_tvalid_i[grant]`.
- `m_axis_tlast_o` and `m_axis_tdata_o` come from source `grant`.
- `s_axis_tready_o[grant]` = `m_axis_tready_i`; all other readies are 0.
- On a handshake with `tlast`=1: set `ptr` to `grant+1`, wrapping to 0 at NUM_SRC, and go to IDLE.

Rules:
- Grant is held until `tlast` regardless of the source's `tvalid`. A mid-packet `tvalid` gap stalls the channel and does not re-arbitrate.
- Requests that change while in HEAD or XFER have no effect until the next IDLE.
- When idle, `grant_o` is all zero. Otherwise it is one-hot of `grant`.
- In states other than XFER, `m_axis_tdata_o` must not depend on the sources.

## Timing

Reset (asynchronous assertion, synchronous release):
- State goes to IDLE; `grant` and `ptr` go to 0.
- `m_axis_tvalid_o`=0, `m_axis_tlast_o`=0, `m_axis_tdata_o`=0, `s_axis_tready_o`=0, `grant_o`=0, `busy_o`=0.

Latency:
- Request sampled in IDLE at edge N gives the header beat valid after edge N, i.e. during cycle N+1.
- The first payload beat can transfer in the cycle after the header handshake.
- With `HEADER`=0, the first payload beat is presented in cycle N+1.

Throughput:
- Within a packet: one beat per cycle, with no added register stage.
- Between packets: one mandatory IDLE cycle, plus the header beat if enabled.

Boundary cases:
- Single-beat packet (`tlast` on the first beat) is legal; the arbiter returns to IDLE after that handshake.
- `ptr` wraps from NUM_SRC-1 to 0.
- A lone requester equal to the previous grant is re-granted after the IDLE cycle.
- Reset mid-packet truncates the output packet with no `tlast` beat. This is accepted; the upstream bulk core discards it on its own reset.
- `m_axis_tready_i` held low in HEAD keeps `tvalid` high and `tdata` stable, as required by AXI-Stream.

## Test plan

- Single source, `HEADER`=1, `NUM_SRC`=4: source 1 sends 3 beats 8'h11, 8'h22, 8'h33 with `tlast` on the last. Required output: 8'hA1, 11, 22, 33, with `tlast` only on 8'h33. `grant_o`=4'b0010 throughout the transfer, then 0.
- All 4 sources assert a 2-beat packet simultaneously and continuously. Required output packet order: sources 0, 1, 2, 3, then 0. Each packet is preceded by its header and separated by exactly one idle cycle.
- Fairness: sources 0 and 3 request continuously. Required grants alternate 0, 3, 0, 3; source 0 never receives two consecutive grants.
- Backpressure: hold `m_axis_tready_i`=0 for 5 cycles in HEAD, then toggle it every cycle during XFER. Required: no beat lost or duplicated, and data stays stable while stalled.
- `HEADER`=0 with a 1-beat packet from source 2. Output is that beat with `tlast`, valid in the cycle after the request; `ptr` becomes 3.
- Assert `areset` on the second beat of a 4-beat packet. Required: all outputs are 0 immediately. After release, a new request from source 1 is granted, confirming `ptr` was reset to 0 and source 1 is the first requester found.
